// File: rtl/display_pkg.sv
// display_pkg: shared FSM encoding and BCD digit constants for the binary-to-BCD converter
package display_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] SAT_DIGIT = 4'd9;
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble digit correction, adds 3 to any digit of 5 or more before the shift
module bcd_add3
    import display_pkg::*;
(
    input  logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter with overflow saturation; define BIN2BCD_SIGNED_EN for two's complement input
module bin2bcd_seq
    import display_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DIGITS     = 5
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_start,
    input  logic [DATA_WIDTH-1:0]      i_data,
    output logic                       o_busy,
    output logic                       o_valid,
    output logic [DIGIT_W*DIGITS-1:0]  o_bcd,
    output logic                       o_sign,
    output logic                       o_overflow
);
    localparam int BW = DIGIT_W * DIGITS;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    state_t                state, state_n;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] sr, mag;
    logic [BW-1:0]         acc, adj;
    logic                  ovf;
    logic [BW+DATA_WIDTH:0] shifted;

    for (genvar i = 0; i < DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (.d(acc[i*DIGIT_W +: DIGIT_W]), .q(adj[i*DIGIT_W +: DIGIT_W]));
    end

    // the top bit of the shifted word is what falls out of the most significant digit
    assign shifted = {adj, sr, 1'b0};
    assign o_busy  = state != IDLE;

`ifdef BIN2BCD_SIGNED_EN
    logic sign_r;

    assign mag = i_data[DATA_WIDTH-1] ? -i_data : i_data;

    // capture the input sign at start, publish it together with the result
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            sign_r <= 1'b0;
            o_sign <= 1'b0;
        end else begin
            if (state == IDLE && i_start) sign_r <= i_data[DATA_WIDTH-1];
            if (state == DONE) o_sign <= sign_r;
        end
    end
`else
    assign mag    = i_data;
    assign o_sign = 1'b0;
`endif

    // state register
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) state <= IDLE;
        else state <= state_n;
    end

    // next-state logic: one shift per input bit, then a single publish cycle
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = i_start ? SHIFT : IDLE;
            SHIFT:   state_n = (cnt == CW'(1)) ? DONE : SHIFT;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // datapath: load on start, correct-and-shift while converting, register results when done
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            cnt        <= '0;
            sr         <= '0;
            acc        <= '0;
            ovf        <= 1'b0;
            o_valid    <= 1'b0;
            o_bcd      <= '0;
            o_overflow <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                IDLE: if (i_start) begin
                    sr  <= mag;
                    acc <= '0;
                    ovf <= 1'b0;
                    cnt <= CW'(DATA_WIDTH);
                end
                SHIFT: begin
                    acc <= shifted[BW+DATA_WIDTH-1:DATA_WIDTH];
                    sr  <= shifted[DATA_WIDTH-1:0];
                    ovf <= ovf | shifted[BW+DATA_WIDTH];
                    cnt <= cnt - CW'(1);
                end
                DONE: begin
                    o_valid    <= 1'b1;
                    o_bcd      <= ovf ? {DIGITS{SAT_DIGIT}} : acc;
                    o_overflow <= ovf;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed table-driven bench for bin2bcd_seq (16-bit/5-digit and 8-bit/2-digit instances)
module tb_bin2bcd_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [15:0] data_a = '0;
    logic [7:0]  data_b = '0;
    logic        busy_a, valid_a, sign_a, ovf_a;
    logic [19:0] bcd_a;
    logic        busy_b, valid_b, sign_b, ovf_b;
    logic [7:0]  bcd_b;
    int          checks = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    bin2bcd_seq dut_a (
        .i_clock(clk), .i_reset(rst_n), .i_start(start_a), .i_data(data_a),
        .o_busy(busy_a), .o_valid(valid_a), .o_bcd(bcd_a), .o_sign(sign_a), .o_overflow(ovf_a)
    );

    bin2bcd_seq #(.DATA_WIDTH(8), .DIGITS(2)) dut_b (
        .i_clock(clk), .i_reset(rst_n), .i_start(start_b), .i_data(data_b),
        .o_busy(busy_b), .o_valid(valid_b), .o_bcd(bcd_b), .o_sign(sign_b), .o_overflow(ovf_b)
    );

    typedef struct {
        bit          sel;
        logic [15:0] data;
        logic [19:0] bcd;
        logic        ovf;
        logic        sign;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // caller must be just after a falling edge
    task automatic run_vec(input vec_t v);
        int   lat = 0;
        logic seen = 1'b0;
        logic [31:0] held;
        if (v.sel) begin data_b = v.data[7:0]; start_b = 1'b1; end
        else begin data_a = v.data; start_a = 1'b1; end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        data_a = ~data_a;
        data_b = ~data_b;
        check("busy_during", 32'(v.sel ? busy_b : busy_a), 32'd1);
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            seen = v.sel ? valid_b : valid_a;
        end
        check($sformatf("latency[%0h]", v.data), 32'(lat), 32'(v.lat));
        check($sformatf("bcd[%0h]", v.data), v.sel ? 32'(bcd_b) : 32'(bcd_a), 32'(v.bcd));
        check($sformatf("ovf[%0h]", v.data), 32'(v.sel ? ovf_b : ovf_a), 32'(v.ovf));
        check($sformatf("sign[%0h]", v.data), 32'(v.sel ? sign_b : sign_a), 32'(v.sign));
        held = v.sel ? 32'(bcd_b) : 32'(bcd_a);
        @(negedge clk);
        check("valid_width", 32'(v.sel ? valid_b : valid_a), 32'd0);
        check("busy_after", 32'(v.sel ? busy_b : busy_a), 32'd0);
        repeat (3) @(negedge clk);
        check("bcd_hold", v.sel ? 32'(bcd_b) : 32'(bcd_a), held);
    endtask

    initial begin
        int first, nv, k;
        int t[$];

        vecs.push_back('{1'b0, 16'd0,     20'h00000, 1'b0, 1'b0, 17});
`ifdef BIN2BCD_SIGNED_EN
        vecs.push_back('{1'b0, 16'hFB2E,  20'h01234, 1'b0, 1'b1, 17});
        vecs.push_back('{1'b0, 16'h8000,  20'h32768, 1'b0, 1'b1, 17});
        vecs.push_back('{1'b0, 16'd7,     20'h00007, 1'b0, 1'b0, 17});
        vecs.push_back('{1'b0, 16'd12345, 20'h12345, 1'b0, 1'b0, 17});
        vecs.push_back('{1'b0, 16'hFFFF,  20'h00001, 1'b0, 1'b1, 17});
        vecs.push_back('{1'b1, 16'd99,    20'h00099, 1'b0, 1'b0, 9});
        vecs.push_back('{1'b1, 16'd100,   20'h00099, 1'b1, 1'b0, 9});
        vecs.push_back('{1'b1, 16'h0080,  20'h00099, 1'b1, 1'b1, 9});
`else
        vecs.push_back('{1'b0, 16'd65535, 20'h65535, 1'b0, 1'b0, 17});
        vecs.push_back('{1'b0, 16'd12345, 20'h12345, 1'b0, 1'b0, 17});
        vecs.push_back('{1'b0, 16'd9999,  20'h09999, 1'b0, 1'b0, 17});
        vecs.push_back('{1'b0, 16'd100,   20'h00100, 1'b0, 1'b0, 17});
        vecs.push_back('{1'b0, 16'd1,     20'h00001, 1'b0, 1'b0, 17});
        vecs.push_back('{1'b1, 16'd99,    20'h00099, 1'b0, 1'b0, 9});
        vecs.push_back('{1'b1, 16'd100,   20'h00099, 1'b1, 1'b0, 9});
        vecs.push_back('{1'b1, 16'd250,   20'h00099, 1'b1, 1'b0, 9});
        vecs.push_back('{1'b1, 16'd7,     20'h00007, 1'b0, 1'b0, 9});
        vecs.push_back('{1'b1, 16'd255,   20'h00099, 1'b1, 1'b0, 9});
`endif

        #2;
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_bcd", 32'(bcd_a), 32'd0);
        check("rst_ovf", 32'(ovf_a), 32'd0);
        check("rst_sign", 32'(sign_a), 32'd0);
        check("rst_bcd_b", 32'(bcd_b), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // a start pulse mid-conversion must be ignored
        data_a = 16'd42;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        first = -1;
        nv = 0;
        for (k = 1; k <= 45; k++) begin
            if (k == 5) begin start_a = 1'b1; data_a = 16'd999; end
            if (k == 6) start_a = 1'b0;
            @(negedge clk);
            if (valid_a) begin
                nv++;
                if (first < 0) first = k;
            end
        end
        check("ignore_first_valid", 32'(first), 32'd17);
        check("ignore_valid_count", 32'(nv), 32'd1);
        check("ignore_bcd", 32'(bcd_a), 32'h00042);

        // start held high gives back-to-back conversions
        data_a = 16'd12345;
        start_a = 1'b1;
        @(negedge clk);
        for (k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (valid_a) t.push_back(k);
        end
        start_a = 1'b0;
        check("held_count", 32'(t.size()), 32'd3);
        if (t.size() >= 3) begin
            check("held_first", 32'(t[0]), 32'd17);
            check("held_period1", 32'(t[1] - t[0]), 32'd18);
            check("held_period2", 32'(t[2] - t[1]), 32'd18);
        end
        check("held_bcd", 32'(bcd_a), 32'h12345);
        k = 0;
        while (busy_a && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("held_drain", 32'(busy_a), 32'd0);
        repeat (2) @(negedge clk);

        // reset in the middle of a conversion aborts it
        data_a = 16'd65535;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_valid", 32'(valid_a), 32'd0);
        check("abort_bcd", 32'(bcd_a), 32'd0);
        check("abort_ovf", 32'(ovf_a), 32'd0);
        check("abort_sign", 32'(sign_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        for (k = 0; k < 25; k++) begin
            @(negedge clk);
            if (valid_a) nv++;
        end
        check("abort_no_valid", 32'(nv), 32'd0);
        run_vec('{1'b0, 16'd4321, 20'h04321, 1'b0, 1'b0, 17});

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
